// File: rtl/pll_supervisor_pkg.sv
// Shared definitions for the PLL supervisor: state encoding and loss-counter width.
package pll_supervisor_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_t;

  localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/pll_supervisor_ce_divider.sv
// One clock-enable channel: divides the RUN period by a ratio that is latched
// at RUN entry and re-latched only when the channel strobes.
module ce_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] ratio,
  output logic             ce
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] ratio_reg;
  logic [DIV_W-1:0] ratio_clamped;
  logic [DIV_W-1:0] eff_ratio;
  logic             active_reg;
  logic             ce_reg;

  // Ratios 0 and 1 both mean "strobe every cycle".
  always_comb begin
    ratio_clamped = (ratio == '0) ? DIV_W'(1) : ratio;
    eff_ratio     = active_reg ? ratio_reg : ratio_clamped;
  end

  // run reflects the next state, so ce lines up with the state register.
  always_ff @(posedge clock_in) begin
    if (reset || !run) begin
      cnt_reg    <= '0;
      ratio_reg  <= '0;
      active_reg <= 1'b0;
      ce_reg     <= 1'b0;
    end else begin
      active_reg <= 1'b1;
      if (cnt_reg == eff_ratio - DIV_W'(1)) begin
        ce_reg    <= 1'b1;
        cnt_reg   <= '0;
        ratio_reg <= ratio_clamped;
      end else begin
        ce_reg    <= 1'b0;
        cnt_reg   <= cnt_reg + DIV_W'(1);
        ratio_reg <= eff_ratio;
      end
    end
  end

  assign ce = ce_reg;

endmodule

// File: rtl/pll_supervisor.sv
// PLL lock supervisor: synchronizes lock, holds reset until lock is stable, then
// generates divided clock enables. Define PLL_SUPERVISOR_LOSS_CNT_EN for loss_count.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int DIV_W         = 8,
  parameter int STABLE_CYCLES = 1024,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    locked_in,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  output logic                    rst_out,
  output logic                    ready,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [1:0]              state_out
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0]   loss_count
`endif
);

  localparam int STAB_W = $clog2(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   lock_s;
  state_t                 state_reg, state_next;
  logic [STAB_W-1:0]      stable_cnt_reg, stable_cnt_next;
  logic                   run_next;

  assign lock_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_reg       <= '0;
      state_reg      <= WAIT_LOCK;
      stable_cnt_reg <= '0;
    end else begin
      sync_reg       <= {sync_reg[SYNC_STAGES-2:0], locked_in};
      state_reg      <= state_next;
      stable_cnt_reg <= stable_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    stable_cnt_next = stable_cnt_reg;
    case (state_reg)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next      = STABILIZE;
          stable_cnt_next = '0;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
        end else if (stable_cnt_reg == STAB_LAST) begin
          state_next = RUN;
        end else begin
          stable_cnt_next = stable_cnt_reg + STAB_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) state_next = LOST;
      end
      LOST:    state_next = WAIT_LOCK;
      default: state_next = WAIT_LOCK;
    endcase
  end

  assign state_out = state_reg;
  assign ready     = (state_reg == RUN);
  assign rst_out   = (state_reg != RUN);
  assign run_next  = (state_next == RUN);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ce_divider #(
        .DIV_W(DIV_W)
      ) u_div (
        .clock_in(clock_in),
        .reset   (reset),
        .run     (run_next),
        .ratio   (div_ratio[gi*DIV_W +: DIV_W]),
        .ce      (ce_out[gi])
      );
    end
  endgenerate

`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_reg;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      loss_cnt_reg <= '0;
    end else if (state_reg == RUN && state_next == LOST && loss_cnt_reg != '1) begin
      loss_cnt_reg <= loss_cnt_reg + LOSS_CNT_W'(1);
    end
  end

  assign loss_count = loss_cnt_reg;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor (STABLE_CYCLES=16, SYNC_STAGES=2) with a
// queue of expected ce_out values consumed as RUN cycles elapse.
module tb_pll_supervisor;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 8;

  logic                    clock_in = 1'b0;
  logic                    reset;
  logic                    locked_in;
  logic [NUM_CH*DIV_W-1:0] div_ratio;
  logic                    rst_out;
  logic                    ready;
  logic [NUM_CH-1:0]       ce_out;
  logic [1:0]              state_out;
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
  logic [7:0]              loss_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [1:0] exp_q[$];

  pll_supervisor #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .STABLE_CYCLES(16), .SYNC_STAGES(2)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .locked_in(locked_in),
    .div_ratio(div_ratio),
    .rst_out  (rst_out),
    .ready    (ready),
    .ce_out   (ce_out),
    .state_out(state_out)
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    ,
    .loss_count(loss_count)
`endif
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %s: got %0h want %0h", tag, obs, exp);
    end else begin
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; counts edges from the first one sampling locked_in high.
  task automatic lock_to_run(input string tag);
    locked_in = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(posedge clock_in);
      @(negedge clock_in);
      if (i == 18) begin
        check({tag, "_edge18_state"}, 32'(state_out), 32'd1);
        check({tag, "_edge18_ready"}, 32'(ready), 32'd0);
      end
    end
    check({tag, "_edge19_state"}, 32'(state_out), 32'd2);
    check({tag, "_edge19_ready"}, 32'(ready), 32'd1);
    check({tag, "_edge19_rst_out"}, 32'(rst_out), 32'd0);
  endtask

  // Drops lock in RUN and checks the single LOST cycle.
  task automatic drop_lock(input string tag);
    bit found = 0;
    locked_in = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clock_in);
      if (state_out == 2'd3) found = 1;
    end
    check({tag, "_lost_seen"}, 32'(found), 32'd1);
    check({tag, "_lost_ce"}, 32'(ce_out), 32'd0);
    check({tag, "_lost_rst_out"}, 32'(rst_out), 32'd1);
    @(negedge clock_in);
    check({tag, "_after_lost_state"}, 32'(state_out), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    locked_in = 1'b0;
    div_ratio = {8'd0, 8'd4};
    repeat (3) @(negedge clock_in);
    check("reset_state", 32'(state_out), 32'd0);
    check("reset_rst_out", 32'(rst_out), 32'd1);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_ce", 32'(ce_out), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock_in);
    check("idle_wait_lock", 32'(state_out), 32'd0);

    // Lock acquisition latency, then ch0 ratio 4 and ch1 ratio 0.
    lock_to_run("acq");
    for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, (c % 4) == 3});
    for (int c = 0; c < 16; c++) begin
      check($sformatf("div4_c%0d", c), 32'(ce_out), 32'(exp_q.pop_front()));
      @(negedge clock_in);
    end
    drop_lock("loss1");

    // Ratio change 4->6 during RUN cycle 5.
    lock_to_run("chg");
    for (int c = 0; c < 22; c++)
      exp_q.push_back({1'b1, (c == 3 || c == 7 || c == 13 || c == 19)});
    for (int c = 0; c < 22; c++) begin
      if (c == 5) div_ratio[7:0] = 8'd6;
      check($sformatf("chg_c%0d", c), 32'(ce_out), 32'(exp_q.pop_front()));
      @(negedge clock_in);
    end
    drop_lock("loss2");

    div_ratio[7:0] = 8'd4;
    lock_to_run("third");
    drop_lock("loss3");
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    check("loss_count_3", 32'(loss_count), 32'd3);
    reset = 1'b1;
    @(negedge clock_in);
    check("loss_count_reset", 32'(loss_count), 32'd0);
    reset = 1'b0;
`endif

    // Short lock pulse must never reach RUN.
    begin
      bit ready_seen = 0;
      locked_in = 1'b1;
      for (int i = 0; i < 40; i++) begin
        if (i == 10) locked_in = 1'b0;
        @(negedge clock_in);
        if (ready) ready_seen = 1;
      end
      check("pulse_no_ready", 32'(ready_seen), 32'd0);
      check("pulse_wait_lock", 32'(state_out), 32'd0);
    end

    // Reset mid-STABILIZE with lock held high restarts the full sequence.
    locked_in = 1'b1;
    repeat (10) @(negedge clock_in);
    check("midstab_state", 32'(state_out), 32'd1);
    reset = 1'b1;
    @(negedge clock_in);
    check("midstab_reset_state", 32'(state_out), 32'd0);
    check("midstab_reset_ce", 32'(ce_out), 32'd0);
    reset = 1'b0;
    lock_to_run("restart");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pll_supervisor.md
PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 Parameter NUM_CH, default 2, number of clock-enable channels (1..8).
REQ-002 Parameter DIV_W, default 8, width of each channel divide ratio.
REQ-003 Parameter STABLE_CYCLES, default 1024, consecutive synchronized-lock cycles required before release (>=2).
REQ-004 Parameter SYNC_STAGES, default 2, flops in the locked_in synchronizer (>=2).
REQ-005 clock_in  input  1  the single clock (PLL output domain); one clock; reset is synchronous and active-high.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 locked_in  input  1  raw PLL lock indication, asynchronous to clock_in.
REQ-008 div_ratio  input  NUM_CH*DIV_W  per-channel divide ratio; channel k occupies bits [k*DIV_W +: DIV_W].
REQ-009 rst_out  output  1  active-high downstream system reset.
REQ-010 ready  output  1  high only in RUN.
REQ-011 ce_out  output  NUM_CH  single-cycle clock-enable strobes.
REQ-012 state_out  output  2  current state encoding.
REQ-013 loss_count  output  8  saturating count of RUN-to-LOST events (present only per REQ-030).

Function
REQ-014 locked_in SHALL pass through SYNC_STAGES flops; only the synchronized value lock_s SHALL be used.
REQ-015 States: WAIT_LOCK=0, STABILIZE=1, RUN=2, LOST=3; state_out SHALL equal the state register.
REQ-016 WAIT_LOCK: lock_s=1 -> STABILIZE with stable counter cleared to 0; else stay.
REQ-017 STABILIZE: lock_s=0 -> WAIT_LOCK; lock_s=1 and counter==STABLE_CYCLES-1 -> RUN; else counter+1.
REQ-018 RUN: lock_s=0 -> LOST; else stay.
REQ-019 LOST: SHALL last exactly one cycle, then WAIT_LOCK unconditionally.
REQ-020 rst_out SHALL be 1 in every state except RUN; ready SHALL be 1 only in RUN; both decoded from the state register (no extra latency).
REQ-021 Latency: with locked_in held high, first RUN cycle SHALL follow SYNC_STAGES+1+STABLE_CYCLES rising edges after the edge first sampling locked_in high.
REQ-022 Each channel SHALL own a DIV_W-bit counter, cleared to 0 in every non-RUN state.
REQ-023 In RUN, channel k: ce_out[k]=1 when counter==eff_ratio-1, counter then returns to 0; otherwise counter+1 and ce_out[k]=0.
REQ-024 eff_ratio SHALL be max(div_ratio_k,1); ratio 0 or 1 gives ce_out[k]=1 every RUN cycle.
REQ-025 eff_ratio SHALL be latched on RUN entry and re-latched only on the cycle the channel strobes; mid-period div_ratio changes SHALL not shorten or lengthen the current period.
REQ-026 ce_out SHALL be registered; first strobe of channel k SHALL occur eff_ratio cycles after RUN entry (cycle index eff_ratio-1, first RUN cycle = 0).
REQ-027 Lock drop during RUN: ce_out SHALL be 0 from the LOST cycle on; partially counted periods discarded.

Reset
REQ-028 On reset=1 at a rising edge: state WAIT_LOCK, synchronizer flops 0, all counters 0, ce_out 0, rst_out 1, ready 0, loss_count 0; reset mid-STABILIZE or mid-RUN SHALL behave identically.

Configuration
REQ-029 Macro PLL_SUPERVISOR_LOSS_CNT_EN controls lock-loss counting.
REQ-030 Defined: loss_count SHALL increment on each RUN->LOST transition, saturating at 255. Undefined: loss_count port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-031 Shared package pll_supervisor_pkg SHALL hold the state encoding constants and LOSS_CNT_W=8.
REQ-032 Per-channel divider SHALL be sub-module ce_divider (parameter DIV_W; ports clock_in, reset, run, ratio, ce), instantiated NUM_CH times via generate.

Verification
REQ-033 STABLE_CYCLES=16, SYNC_STAGES=2, locked_in raised and held -> state_out=RUN and ready=1 exactly 19 edges later; rst_out falls same cycle.
REQ-034 locked_in pulsed high for 10 cycles then low (STABLE_CYCLES=16) -> returns to WAIT_LOCK, ready never asserts.
REQ-035 RUN, div_ratio ch0=4, ch1=0 -> ce_out[0] on RUN cycles 3,7,11...; ce_out[1] every cycle.
REQ-036 RUN, ch0 ratio changed 4->6 on RUN cycle 5 -> strobes at 3,7, then 13,19.
REQ-037 locked_in dropped in RUN, three times with macro defined -> one LOST cycle each, ce_out=0, loss_count=3; reset -> loss_count=0.
REQ-038 reset asserted mid-STABILIZE with locked_in high -> WAIT_LOCK next cycle, full 19-edge sequence restarts after reset release.
